// File: rtl/ysyx_25030081_dmem_slave.sv
// Fixed-latency data-memory responder for the ysyx_25030081 load/store port.
// Handles one request at a time with RV32 byte/half/word access rules and error flagging.
module ysyx_25030081_dmem_slave #(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state;
    logic [7:0]  cnt;
    logic        wen_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  op_q;

    logic [31:0] mem [DEPTH];

    logic [31:0]   off;
    logic          in_range;
    logic          misaligned;
    logic          illegal;
    logic          err;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   rword;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   load_data;
    logic [3:0]    wmask;
    logic [31:0]   wdata_rep;
    logic          exec;

    always_comb begin
        off      = addr_q - BASE;
        in_range = (addr_q >= BASE) && ({1'b0, off} < (33'(DEPTH) * 33'd4));
        idx      = off[AW+1:2];
        lane     = addr_q[1:0];

        misaligned = 1'b0;
        case (op_q[1:0])
            2'b01:   misaligned = addr_q[0];
            2'b10:   misaligned = |addr_q[1:0];
            default: misaligned = 1'b0;
        endcase

        // Unsigned variants only exist for loads.
        illegal = (op_q == 3'b011) || (op_q[2:1] == 2'b11) || (wen_q && op_q[2]);
        err     = !in_range || misaligned || illegal;

        rword = mem[idx];
        rbyte = 8'(rword >> {lane, 3'b000});
        rhalf = addr_q[1] ? rword[31:16] : rword[15:0];

        load_data = 32'h0;
        case (op_q)
            3'b000:  load_data = {{24{rbyte[7]}}, rbyte};
            3'b100:  load_data = {24'h0, rbyte};
            3'b001:  load_data = {{16{rhalf[15]}}, rhalf};
            3'b101:  load_data = {16'h0, rhalf};
            3'b010:  load_data = rword;
            default: load_data = 32'h0;
        endcase

        wmask     = 4'b0000;
        wdata_rep = wdata_q;
        case (op_q[1:0])
            2'b00: begin
                wmask     = 4'b0001 << lane;
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wmask     = 4'b0011 << lane;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                wmask     = 4'b1111;
                wdata_rep = wdata_q;
            end
            default: begin
                wmask     = 4'b0000;
                wdata_rep = wdata_q;
            end
        endcase

        // The access executes on the single edge that moves WAIT into RESP.
        exec = (state == StWait) && (cnt == 8'd0) && !rst;
    end

    // Array is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (exec && wen_q && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[idx][i*8 +: 8] <= wdata_rep[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            cnt        <= 8'd0;
            wen_q      <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            op_q       <= 3'b000;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        wen_q     <= req_wen;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        op_q      <= req_op;
                        cnt       <= 8'(LATENCY);
                        state     <= StWait;
                        req_ready <= 1'b0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                StWait: begin
                    if (cnt == 8'd0) begin
                        state      <= StResp;
                        resp_valid <= 1'b1;
                        resp_err   <= err;
                        resp_rdata <= (wen_q || err) ? 32'h0 : load_data;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        state      <= StIdle;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= StIdle;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25030081_dmem_slave.sv
// Directed bench for ysyx_25030081_dmem_slave: one LATENCY=2 instance and one LATENCY=0
// instance sharing stimulus, selected by sel.
module tb_ysyx_25030081_dmem_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [2:0]  op = 3'b000;
    logic        resp_ready = 1'b1;

    logic        ready_a, valid_a, err_a;
    logic [31:0] rdata_a;
    logic        ready_b, valid_b, err_b;
    logic [31:0] rdata_b;

    logic        ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    ysyx_25030081_dmem_slave #(.BASE(32'h8000_0000), .DEPTH(1024), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid & ~sel),
        .req_ready  (ready_a),
        .req_wen    (wen),
        .req_addr   (addr),
        .req_wdata  (wdata),
        .req_op     (op),
        .resp_valid (valid_a),
        .resp_ready (resp_ready & ~sel),
        .resp_rdata (rdata_a),
        .resp_err   (err_a)
    );

    ysyx_25030081_dmem_slave #(.BASE(32'h8000_0000), .DEPTH(1024), .LATENCY(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid & sel),
        .req_ready  (ready_b),
        .req_wen    (wen),
        .req_addr   (addr),
        .req_wdata  (wdata),
        .req_op     (op),
        .resp_valid (valid_b),
        .resp_ready (resp_ready & sel),
        .resp_rdata (rdata_b),
        .resp_err   (err_b)
    );

    assign ready      = sel ? ready_b : ready_a;
    assign resp_valid = sel ? valid_b : valid_a;
    assign resp_rdata = sel ? rdata_b : rdata_a;
    assign resp_err   = sel ? err_b   : err_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] o, output logic [31:0] rd, output logic er,
                          output int lat);
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        wen        = w;
        addr       = a;
        wdata      = d;
        op         = o;
        resp_ready = 1'b1;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 300) begin
            @(posedge clk);
            #1 lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] o, input logic [31:0] exp_rd,
                        input logic exp_er, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(w, a, d, o, rd, er, lat);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 32'(er), 32'(exp_er));
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    // Store accepted, then reset before it executes; store must be dropped.
    task automatic reset_during_store(input string tag, input logic [31:0] a,
                                      input logic [31:0] d);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        wen       = 1'b1;
        addr      = a;
        wdata     = d;
        op        = 3'b010;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, 32'(ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_rst_ready"}, 32'(ready), 32'd0);
        check({tag, "_rst_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_rst_rdata"}, resp_rdata, 32'h0);
        check({tag, "_rst_err"}, 32'(resp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        // Reset state
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_ready", 32'(ready_a), 32'd0);
        check("reset_valid", 32'(valid_a), 32'd0);
        check("reset_rdata", rdata_a, 32'h0);
        check("reset_err", 32'(err_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_ready", 32'(ready_a), 32'd1);

        // Word store/load
        xact("sw_10", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0, 3);
        xact("lw_10", 1'b0, 32'h8000_0010, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, 3);

        // Extension
        xact("lb_13", 1'b0, 32'h8000_0013, 32'h0, 3'b000, 32'hFFFF_FFDE, 1'b0, 3);
        xact("lbu_13", 1'b0, 32'h8000_0013, 32'h0, 3'b100, 32'h0000_00DE, 1'b0, 3);
        xact("lh_12", 1'b0, 32'h8000_0012, 32'h0, 3'b001, 32'hFFFF_DEAD, 1'b0, 3);
        xact("lhu_10", 1'b0, 32'h8000_0010, 32'h0, 3'b101, 32'h0000_BEEF, 1'b0, 3);

        // Partial stores
        xact("sb_11", 1'b1, 32'h8000_0011, 32'hAAAA_AA12, 3'b000, 32'h0, 1'b0, 3);
        xact("sh_12", 1'b1, 32'h8000_0012, 32'hBBBB_5566, 3'b001, 32'h0, 1'b0, 3);
        xact("lw_part", 1'b0, 32'h8000_0010, 32'h0, 3'b010, 32'h5566_12EF, 1'b0, 3);

        // Last word in range
        xact("sw_last", 1'b1, 32'h8000_0FFC, 32'h1234_5678, 3'b010, 32'h0, 1'b0, 3);
        xact("lw_last", 1'b0, 32'h8000_0FFC, 32'h0, 3'b010, 32'h1234_5678, 1'b0, 3);

        // Errors
        xact("lw_mis", 1'b0, 32'h8000_0012, 32'h0, 3'b010, 32'h0, 1'b1, 3);
        xact("lh_mis", 1'b0, 32'h8000_0011, 32'h0, 3'b001, 32'h0, 1'b1, 3);
        xact("sw_oor", 1'b1, 32'h8000_1000, 32'h1111_1111, 3'b010, 32'h0, 1'b1, 3);
        xact("op_011", 1'b0, 32'h8000_0010, 32'h0, 3'b011, 32'h0, 1'b1, 3);
        xact("lw_low", 1'b0, 32'h7FFF_FFFC, 32'h0, 3'b010, 32'h0, 1'b1, 3);
        xact("sw_mis", 1'b1, 32'h8000_0012, 32'h0000_0000, 3'b010, 32'h0, 1'b1, 3);
        xact("sbu_ill", 1'b1, 32'h8000_0010, 32'h0000_0000, 3'b100, 32'h0, 1'b1, 3);
        xact("lw_after_err", 1'b0, 32'h8000_0010, 32'h0, 3'b010, 32'h5566_12EF, 1'b0, 3);
        xact("lw_last_after", 1'b0, 32'h8000_0FFC, 32'h0, 3'b010, 32'h1234_5678, 1'b0, 3);

        // Backpressure
        @(negedge clk);
        req_valid  = 1'b1;
        wen        = 1'b0;
        addr       = 32'h8000_0010;
        op         = 3'b010;
        resp_ready = 1'b0;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_accept", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        check("bp_lat", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(resp_valid), 32'd1);
            check("bp_hold_rdata", resp_rdata, 32'h5566_12EF);
            check("bp_hold_ready", 32'(ready), 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(resp_valid), 32'd0);
        check("bp_release_ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        check("bp_second_accept", 32'(ready), 32'd0);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        check("bp_second_rdata", resp_rdata, 32'h5566_12EF);
        @(posedge clk);
        #1;

        // Reset during WAIT drops the store
        reset_during_store("rst_l2", 32'h8000_0010, 32'hCAFE_F00D);
        xact("lw_after_rst", 1'b0, 32'h8000_0010, 32'h0, 3'b010, 32'h5566_12EF, 1'b0, 3);

        // Zero-latency instance
        sel = 1'b1;
        @(posedge clk);
        #1;
        xact("l0_sw", 1'b1, 32'h8000_0020, 32'h1122_3344, 3'b010, 32'h0, 1'b0, 1);
        xact("l0_lw", 1'b0, 32'h8000_0020, 32'h0, 3'b010, 32'h1122_3344, 1'b0, 1);
        xact("l0_lbu", 1'b0, 32'h8000_0021, 32'h0, 3'b100, 32'h0000_0033, 1'b0, 1);
        reset_during_store("rst_l0", 32'h8000_0020, 32'hFFFF_FFFF);
        xact("l0_lw_after_rst", 1'b0, 32'h8000_0020, 32'h0, 3'b010, 32'h1122_3344, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
